gsi_jtag_tap_responder: RTL and testbench

- Oversampled IEEE 1149.1 TAP responder for the target side of the GSI SRAM JTAG ID interface.
- Runs on the system clock and samples externally driven TCK/TMS/TDI.
- Returns a parameterised 32-bit IDCODE on TDO, with IDCODE selected after reset or Test-Logic-Reset.
- Used as an on-board SRAM stand-in and as a loopback target for the ID-read initiator.

---
 rtl/gsi_jtag_tap_responder.sv | 156 +++++++++++++++
 tb/tb_gsi_jtag_tap_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gsi_jtag_tap_responder.sv
// ============================================================================
// Module  : gsi_jtag_tap_responder
// Purpose : Oversampled IEEE 1149.1 TAP target returning a fixed IDCODE.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module gsi_jtag_tap_responder #(
  parameter logic [31:0]     IDCODE     = 32'h000A01B3,
  parameter int              IR_W       = 3,
  parameter logic [IR_W-1:0] INS_IDCODE = 3'b001,
  parameter logic [IR_W-1:0] INS_BYPASS = 3'b111
) (
  input  logic            i_clk,
  input  logic            i_resetb,
  input  logic            TCK,
  input  logic            TMS,
  input  logic            TDI,
  output logic            TDO,
  output logic            o_tdo_en,
  output logic [3:0]      o_tap_state,
  output logic [IR_W-1:0] o_ir,
  output logic            o_idcode_sel
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_state_e;

  localparam logic [IR_W-1:0] IR_CAPTURE = {{(IR_W-1){1'b0}}, 1'b1};

  // [0],[1] synchronise; [2] is history used for edge detect and alignment
  logic [2:0]      tck_sync_q, tck_sync_d;
  logic [2:0]      tms_sync_q, tms_sync_d;
  logic [2:0]      tdi_sync_q, tdi_sync_d;
  tap_state_e      state_q, state_d, state_nxt;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [IR_W-1:0] ir_sh_q, ir_sh_d;
  logic [31:0]     dr_q, dr_d;
  logic            byp_q, byp_d;
  logic            tdo_q, tdo_d;
  logic            tdo_en_q, tdo_en_d;

  logic tck_rise, tck_fall, tms_s, tdi_s, idcode_sel, bypass_sel;

  assign tck_rise   = tck_sync_q[1] & ~tck_sync_q[2];
  assign tck_fall   = ~tck_sync_q[1] & tck_sync_q[2];
  assign tms_s      = tms_sync_q[2];
  assign tdi_s      = tdi_sync_q[2];
  assign idcode_sel = (ir_q == INS_IDCODE);
  // Undefined opcodes fall back to the bypass register as well
  assign bypass_sel = (ir_q == INS_BYPASS) | ~idcode_sel;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      TLR:     state_nxt = tms_s ? TLR    : RTI;
      RTI:     state_nxt = tms_s ? SEL_DR : RTI;
      SEL_DR:  state_nxt = tms_s ? SEL_IR : CAP_DR;
      CAP_DR:  state_nxt = tms_s ? EX1_DR : SH_DR;
      SH_DR:   state_nxt = tms_s ? EX1_DR : SH_DR;
      EX1_DR:  state_nxt = tms_s ? UPD_DR : PAU_DR;
      PAU_DR:  state_nxt = tms_s ? EX2_DR : PAU_DR;
      EX2_DR:  state_nxt = tms_s ? UPD_DR : SH_DR;
      UPD_DR:  state_nxt = tms_s ? SEL_DR : RTI;
      SEL_IR:  state_nxt = tms_s ? TLR    : CAP_IR;
      CAP_IR:  state_nxt = tms_s ? EX1_IR : SH_IR;
      SH_IR:   state_nxt = tms_s ? EX1_IR : SH_IR;
      EX1_IR:  state_nxt = tms_s ? UPD_IR : PAU_IR;
      PAU_IR:  state_nxt = tms_s ? EX2_IR : PAU_IR;
      EX2_IR:  state_nxt = tms_s ? UPD_IR : SH_IR;
      UPD_IR:  state_nxt = tms_s ? SEL_DR : RTI;
      default: state_nxt = TLR;
    endcase
  end

  always_comb begin
    tck_sync_d = {tck_sync_q[1:0], TCK};
    tms_sync_d = {tms_sync_q[1:0], TMS};
    tdi_sync_d = {tdi_sync_q[1:0], TDI};
    state_d    = state_q;
    ir_d       = ir_q;
    ir_sh_d    = ir_sh_q;
    dr_d       = dr_q;
    byp_d      = byp_q;
    tdo_d      = tdo_q;
    tdo_en_d   = tdo_en_q;

    if (tck_rise) begin
      state_d = state_nxt;
      case (state_q)
        CAP_DR: begin
          if (idcode_sel) dr_d  = IDCODE;
          if (bypass_sel) byp_d = 1'b0;
        end
        SH_DR: begin
          if (idcode_sel) dr_d  = {tdi_s, dr_q[31:1]};
          if (bypass_sel) byp_d = tdi_s;
        end
        CAP_IR:  ir_sh_d = IR_CAPTURE;
        SH_IR:   ir_sh_d = {tdi_s, ir_sh_q[IR_W-1:1]};
        default: ;
      endcase
    end

    // Output side moves on the falling edge so TDO is settled by the next rise
    if (tck_fall) begin
      case (state_q)
        UPD_IR:  ir_d  = ir_sh_q;
        TLR:     ir_d  = INS_IDCODE;
        SH_DR:   tdo_d = idcode_sel ? dr_q[0] : byp_q;
        SH_IR:   tdo_d = ir_sh_q[0];
        default: ;
      endcase
      tdo_en_d = (state_q == SH_DR) || (state_q == SH_IR);
    end
  end

  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      tck_sync_q <= 3'b000;
      tms_sync_q <= 3'b000;
      tdi_sync_q <= 3'b000;
      state_q    <= TLR;
      ir_q       <= INS_IDCODE;
      ir_sh_q    <= IR_CAPTURE;
      dr_q       <= IDCODE;
      byp_q      <= 1'b0;
      tdo_q      <= 1'b0;
      tdo_en_q   <= 1'b0;
    end else begin
      tck_sync_q <= tck_sync_d;
      tms_sync_q <= tms_sync_d;
      tdi_sync_q <= tdi_sync_d;
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_sh_q    <= ir_sh_d;
      dr_q       <= dr_d;
      byp_q      <= byp_d;
      tdo_q      <= tdo_d;
      tdo_en_q   <= tdo_en_d;
    end
  end

  assign TDO          = tdo_q;
  assign o_tdo_en     = tdo_en_q;
  assign o_tap_state  = state_q;
  assign o_ir         = ir_q;
  assign o_idcode_sel = idcode_sel;

endmodule

`default_nettype wire

// File: tb/tb_gsi_jtag_tap_responder.sv
// ============================================================================
// Module  : tb_gsi_jtag_tap_responder
// Purpose : Scoreboard bench for the oversampled JTAG TAP responder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gsi_jtag_tap_responder;

  logic       i_clk = 1'b0;
  logic       i_resetb = 1'b0;
  logic       TCK = 1'b0;
  logic       TMS = 1'b0;
  logic       TDI = 1'b0;
  logic       TDO;
  logic       o_tdo_en;
  logic [3:0] o_tap_state;
  logic [2:0] o_ir;
  logic       o_idcode_sel;

  gsi_jtag_tap_responder dut (
    .i_clk       (i_clk),
    .i_resetb    (i_resetb),
    .TCK         (TCK),
    .TMS         (TMS),
    .TDI         (TDI),
    .TDO         (TDO),
    .o_tdo_en    (o_tdo_en),
    .o_tap_state (o_tap_state),
    .o_ir        (o_ir),
    .o_idcode_sel(o_idcode_sel)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] st;
    logic [2:0] ir;
    logic       sel;
    logic       en;
    logic       chk;
    logic       tdo;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [3:0]  m_state = 4'd0;
  logic [2:0]  m_ir = 3'b001;
  logic [2:0]  ir_load_val = 3'b001;
  logic [31:0] id_word = 32'd0;
  logic [31:0] id_ref = 32'h000A01B3;

  // Reference successor tables, indexed by state code: TMS=0 and TMS=1
  logic [3:0] nx0 [0:15] = '{4'd1, 4'd1, 4'd3, 4'd4, 4'd4, 4'd6, 4'd6, 4'd4,
                             4'd1, 4'd10, 4'd11, 4'd11, 4'd13, 4'd13, 4'd11, 4'd1};
  logic [3:0] nx1 [0:15] = '{4'd0, 4'd2, 4'd9, 4'd5, 4'd5, 4'd8, 4'd7, 4'd8,
                             4'd2, 4'd0, 4'd12, 4'd12, 4'd15, 4'd14, 4'd15, 4'd2};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // One TCK period: inputs change with the fall, expectation queued at the rise
  task automatic pulse(input logic tms, input logic tdi, input logic c,
                       input logic etdo, input int half);
    exp_t e;
    TCK = 1'b0;
    TMS = tms;
    TDI = tdi;
    repeat (half) @(negedge i_clk);
    if (m_state == 4'd0)       m_ir = 3'b001;
    else if (m_state == 4'd15) m_ir = ir_load_val;
    e.st  = m_state;
    e.ir  = m_ir;
    e.sel = (m_ir == 3'b001);
    e.en  = (m_state == 4'd4) || (m_state == 4'd11);
    e.chk = c;
    e.tdo = etdo;
    sb_q.push_back(e);
    TCK = 1'b1;
    m_state = tms ? nx1[m_state] : nx0[m_state];
    repeat (half) @(negedge i_clk);
  endtask

  always @(posedge TCK) begin
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("tap_state", {28'd0, o_tap_state}, {28'd0, e.st});
      chk("ir", {29'd0, o_ir}, {29'd0, e.ir});
      chk("idcode_sel", {31'd0, o_idcode_sel}, {31'd0, e.sel});
      chk("tdo_en", {31'd0, o_tdo_en}, {31'd0, e.en});
      if (e.chk) begin
        chk("tdo", {31'd0, TDO}, {31'd0, e.tdo});
        id_word = {TDO, id_word[31:1]};
      end
    end
  end

  task automatic id_read(input int half);
    id_word = 32'd0;
    for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0, half);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, half);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, half);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, half);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, half);
    for (int i = 0; i < 32; i++) pulse(1'b0, 1'b0, 1'b1, id_ref[i], half);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, half);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, half);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, half);
    chk("id_word", id_word, 32'h000A01B3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge i_clk);
    #1;
    chk("rst_state", {28'd0, o_tap_state}, 32'd0);
    chk("rst_ir", {29'd0, o_ir}, 32'd1);
    chk("rst_sel", {31'd0, o_idcode_sel}, 32'd1);
    chk("rst_tdo", {31'd0, TDO}, 32'd0);
    chk("rst_tdo_en", {31'd0, o_tdo_en}, 32'd0);
    @(negedge i_clk);
    i_resetb = 1'b1;
    @(negedge i_clk);

    // ID read at TCK = i_clk/10
    id_read(5);

    // Reset asserted in the middle of a DR shift
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 5);
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 1'b1, id_ref[i], 5);
    TCK = 1'b0;
    repeat (2) @(negedge i_clk);
    #2 i_resetb = 1'b0;
    #1;
    chk("midrst_state", {28'd0, o_tap_state}, 32'd0);
    chk("midrst_ir", {29'd0, o_ir}, 32'd1);
    chk("midrst_tdo", {31'd0, TDO}, 32'd0);
    chk("midrst_tdo_en", {31'd0, o_tdo_en}, 32'd0);
    m_state = 4'd0;
    m_ir = 3'b001;
    @(negedge i_clk);
    i_resetb = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge i_clk);
      TMS = ~TMS;
      TDI = i[1];
    end
    chk("idle_state", {28'd0, o_tap_state}, 32'd0);
    chk("idle_ir", {29'd0, o_ir}, 32'd1);
    chk("idle_tdo", {31'd0, TDO}, 32'd0);
    chk("idle_tdo_en", {31'd0, o_tdo_en}, 32'd0);

    // Load BYPASS, checking the IR capture pattern on the way out
    ir_load_val = 3'b111;
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b1, 1'b1, 1'b1, 5);
    pulse(1'b0, 1'b1, 1'b1, 1'b0, 5);
    pulse(1'b1, 1'b1, 1'b1, 1'b0, 5);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 5);
    // Bypass DR shift: TDI 1,0,1,1 -> TDO 0,1,0,1,1
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b1, 1'b1, 1'b0, 5);
    pulse(1'b0, 1'b0, 1'b1, 1'b1, 5);
    pulse(1'b0, 1'b1, 1'b1, 1'b0, 5);
    pulse(1'b0, 1'b1, 1'b1, 1'b1, 5);
    pulse(1'b1, 1'b0, 1'b1, 1'b1, 5);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 5);

    // Undefined opcode 3'b010
    ir_load_val = 3'b010;
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b0, 1'b1, 1'b1, 5);
    pulse(1'b0, 1'b1, 1'b1, 1'b0, 5);
    pulse(1'b1, 1'b0, 1'b1, 1'b0, 5);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 5);
    // DR path must act as a 1-bit bypass
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b1, 1'b1, 1'b0, 5);
    pulse(1'b1, 1'b0, 1'b1, 1'b1, 5);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 5);

    // Walk to PAU_IR (capture only, so the IR shifter holds 3'b001)
    ir_load_val = 3'b001;
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 5);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 5);
    // Five TMS=1 rises; the sixth rise observes TLR
    for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0, 5);

    // Minimum-timing stress: 4 i_clk per TCK phase
    id_read(4);

    TCK = 1'b0;
    repeat (10) @(negedge i_clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
